pixel_streamer: RTL and testbench



---
 rtl/pixel_streamer_if.sv | 28 ++
 rtl/pixel_streamer.sv | 148 ++++++++++++++
 tb/tb_pixel_streamer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pixel_streamer_if.sv
// Pixel-stream and frame-memory bus between pixel_streamer and its neighbours.
// master = streamer side, slave = memory/pipeline side.
interface pixel_streamer_if #(
    parameter int LOC_SIZE   = 11,
    parameter int PIXEL_SIZE = 24,
    parameter int ADDR_WIDTH = 19
);
    // Handshake: mem_rd is a read strobe, and mem_data is valid exactly one cycle later.
    // en is a valid-only strobe with no ready. The sink throttles the source upstream
    // with stall. x/y/data are meaningful only in cycles where en is high.
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [PIXEL_SIZE-1:0] mem_data;
    logic                  en;
    logic [LOC_SIZE-1:0]   x;
    logic [LOC_SIZE-1:0]   y;
    logic [PIXEL_SIZE-1:0] data;

    modport master (
        output mem_rd, mem_addr, en, x, y, data,
        input  mem_data
    );

    modport slave (
        input  mem_rd, mem_addr, en, x, y, data,
        output mem_data
    );
endinterface

// File: rtl/pixel_streamer.sv
// Raster frame source: reads frame memory in raster order and emits one pixel per cycle.
// Optional PIXEL_STREAMER_FLUSH_EN appends two blank rows to drain downstream row buffers.
module pixel_streamer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int LOC_SIZE     = 11,
    parameter int PIXEL_SIZE   = 24,
    parameter int ADDR_WIDTH   = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    pixel_streamer_if.master       bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [1:0]             dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [LOC_SIZE-1:0] X_LAST = LOC_SIZE'(FRAME_WIDTH - 1);
    localparam logic [LOC_SIZE-1:0] Y_LAST = LOC_SIZE'(FRAME_HEIGHT - 1);
`ifdef PIXEL_STREAMER_FLUSH_EN
    localparam logic [LOC_SIZE-1:0] Y_FLUSH_LAST = LOC_SIZE'(FRAME_HEIGHT + 1);
`endif

    state_t                state_q, state_d;
    logic [LOC_SIZE-1:0]   ix_q, ix_d;
    logic [LOC_SIZE-1:0]   iy_q, iy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  en_q;
    logic [LOC_SIZE-1:0]   x_q;
    logic [LOC_SIZE-1:0]   y_q;
    logic                  blank_q;
    logic                  done_q;
    logic                  issue;
    logic                  flush_issue;

    always_comb begin
        state_d     = state_q;
        ix_d        = ix_q;
        iy_d        = iy_q;
        addr_d      = addr_q;
        issue       = 1'b0;
        flush_issue = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    ix_d    = '0;
                    iy_d    = '0;
                    addr_d  = '0;
                end
            end

            S_STREAM: begin
                if (!stall) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (ix_q == X_LAST) begin
                        ix_d = '0;
                        iy_d = iy_q + 1'b1;
                    end else begin
                        ix_d = ix_q + 1'b1;
                    end
                    if (ix_q == X_LAST && iy_q == Y_LAST) begin
`ifdef PIXEL_STREAMER_FLUSH_EN
                        state_d = S_FLUSH;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end

`ifdef PIXEL_STREAMER_FLUSH_EN
            // Counters keep running past the last row so y reads H, H+1 here.
            S_FLUSH: begin
                if (!stall) begin
                    flush_issue = 1'b1;
                    if (ix_q == X_LAST) begin
                        ix_d = '0;
                        iy_d = iy_q + 1'b1;
                    end else begin
                        ix_d = ix_q + 1'b1;
                    end
                    if (ix_q == X_LAST && iy_q == Y_FLUSH_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ix_q    <= '0;
            iy_q    <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            addr_q  <= addr_d;
            en_q    <= issue | flush_issue;
            if (issue | flush_issue) begin
                x_q     <= ix_q;
                y_q     <= iy_q;
                blank_q <= flush_issue;
            end
            // The final en coincides with DONE, so the pulse lands one cycle later.
            done_q  <= (state_q == S_DONE);
        end
    end

    assign bus.mem_rd   = issue;
    assign bus.mem_addr = addr_q;
    assign bus.en       = en_q;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.data     = blank_q ? '0 : bus.mem_data;

    assign frame_done  = done_q;
    assign busy        = (state_q != S_IDLE) || done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer on a 4x3 frame with memory word = address.
// Honours PIXEL_STREAMER_FLUSH_EN when defined.
module tb_pixel_streamer;
    localparam int W   = 4;
    localparam int H   = 3;
    localparam int LOC = 11;
    localparam int PIX = 24;
    localparam int AW  = 19;
    localparam int N   = W * H;
`ifdef PIXEL_STREAMER_FLUSH_EN
    localparam int FL  = 2 * W;
`else
    localparam int FL  = 0;
`endif
    localparam int EW  = 16 + 2 * LOC + PIX;
    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       busy;
    logic       frame_done;
    logic [1:0] dbg_state;

    pixel_streamer_if #(.LOC_SIZE(LOC), .PIXEL_SIZE(PIX), .ADDR_WIDTH(AW)) bus_if ();

    pixel_streamer #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .LOC_SIZE(LOC),
        .PIXEL_SIZE(PIX), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .bus(bus_if), .busy(busy), .frame_done(frame_done), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // frame memory: word = address, one-cycle read latency
    always @(posedge clk) begin
        if (bus_if.mem_rd) bus_if.mem_data <= PIX'(bus_if.mem_addr);
    end

    // scoreboard
    logic [EW-1:0] exp_q[$];
    bit            exp_rd[0:MAXC-1];
    int            exp_addr[0:MAXC-1];
    int            fd_cyc;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Build expected pixels/reads for one frame given a stall window.
    task automatic plan_frame(input int st_lo, input int st_hi);
        int c;
        int k;
        int d;
        exp_q.delete();
        for (int i = 0; i < MAXC; i++) begin
            exp_rd[i]   = 1'b0;
            exp_addr[i] = 0;
        end
        c = 1;
        k = 0;
        while (k < N + FL && c < MAXC - 4) begin
            if (!(c >= st_lo && c <= st_hi)) begin
                exp_rd[c]   = (k < N);
                exp_addr[c] = k;
                d = (k < N) ? k : 0;
                exp_q.push_back({16'(c + 1), LOC'(k % W), LOC'(k / W), PIX'(d)});
                k++;
            end
            c++;
        end
        fd_cyc = c + 1;
    endtask

    task automatic run_frame(input int st_lo, input int st_hi, input int restart_cyc,
                             input int reset_cyc);
        logic [EW-1:0] e;
        plan_frame(st_lo, st_hi);
        for (int cyc = 0; cyc <= fd_cyc + 1; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (cyc == restart_cyc);
            stall = (cyc >= st_lo) && (cyc <= st_hi);
            reset = (cyc == reset_cyc);
            #1;
            if (reset_cyc >= 0 && cyc == reset_cyc + 1) begin
                chk("rst_en", 64'(bus_if.en), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_x", 64'(bus_if.x), 64'(0));
                chk("rst_y", 64'(bus_if.y), 64'(0));
                chk("rst_done", 64'(frame_done), 64'(0));
                chk("rst_rd", 64'(bus_if.mem_rd), 64'(0));
                exp_q.delete();
                break;
            end
            chk("mem_rd", 64'(bus_if.mem_rd), 64'(exp_rd[cyc]));
            if (exp_rd[cyc]) chk("mem_addr", 64'(bus_if.mem_addr), 64'(exp_addr[cyc]));
            chk("busy", 64'(busy), 64'((cyc >= 1) && (cyc <= fd_cyc)));
            chk("frame_done", 64'(frame_done), 64'(cyc == fd_cyc));
            if (bus_if.en) begin
                if (exp_q.size() == 0) begin
                    chk("en_extra", 64'(bus_if.en), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("en_cycle", 64'(cyc), 64'(e[EW-1 -: 16]));
                    chk("x", 64'(bus_if.x), 64'(e[2*LOC+PIX-1 -: LOC]));
                    chk("y", 64'(bus_if.y), 64'(e[LOC+PIX-1 -: LOC]));
                    chk("data", 64'(bus_if.data), 64'(e[PIX-1:0]));
                end
            end
        end
        start = 1'b0;
        stall = 1'b0;
        reset = 1'b0;
        if (reset_cyc < 0) chk("leftover", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("init_en", 64'(bus_if.en), 64'(0));
        chk("init_x", 64'(bus_if.x), 64'(0));
        chk("init_y", 64'(bus_if.y), 64'(0));
        chk("init_rd", 64'(bus_if.mem_rd), 64'(0));
        chk("init_addr", 64'(bus_if.mem_addr), 64'(0));
        chk("init_busy", 64'(busy), 64'(0));
        chk("init_done", 64'(frame_done), 64'(0));
        chk("init_state", 64'(dbg_state), 64'(0));

        run_frame(-1, -2, -1, -1);      // plain frame
        run_frame(4, 6, -1, -1);        // stall cycles 4-6
        run_frame(-1, -2, 6, -1);       // start re-pulsed mid-frame
        run_frame(-1, -2, -1, 7);       // reset mid-frame
        repeat (2) @(negedge clk);
        run_frame(-1, -2, -1, -1);      // replay after reset
        run_frame($urandom_range(2, 8), $urandom_range(8, 11), -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
